cycle_steal_arbiter: RTL and testbench

CYCLE_STEAL_ARBITER -- requirements
Module: cycle_steal_arbiter

---
 rtl/cycle_steal_arbiter_pkg.sv | 40 ++++
 rtl/cycle_steal_arbiter_inc_fifo.sv | 55 +++++
 rtl/cycle_steal_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cycle_steal_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_steal_arbiter_pkg.sv
// Shared types and constants for the cycle-steal arbiter. The counters are
// stored in a 15-bit ones-complement erasable memory.
package cycle_steal_arbiter_pkg;

  localparam int WORD_W = 15;
  localparam int ADDR_W = 12;
  localparam int IDX_W  = 5;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t POS_ZERO  = 15'h0000;
  localparam word_t NEG_ZERO  = 15'h7FFF;
  localparam word_t MINUS_ONE = 15'h7FFE;
  localparam word_t PLUS_ONE  = 15'h0001;

  localparam logic [ADDR_W-1:0] CNT_BASE_DEFAULT = 12'd20;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RD,
    CPU_RDW,
    CPU_WR,
    CI_RD,
    CI_MOD,
    CI_WR
  } arb_state_t;

  // One pending increment: counter index and direction (1 = MINC).
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dir;
  } cinc_req_t;

  // Counter address; the index is zero-extended and the sum wraps at 2^12.
  function automatic logic [ADDR_W-1:0] counter_addr(input logic [ADDR_W-1:0] base,
                                                      input logic [IDX_W-1:0]  idx);
    return base + {{(ADDR_W-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/cycle_steal_arbiter_inc_fifo.sv
// Pending-increment FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle, so the occupancy stays at DEPTH.
module inc_fifo
  import cycle_steal_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  cinc_req_t push_data,
  input  logic      pop,
  output cinc_req_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cinc_req_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cycle_steal_arbiter.sv
// Shares one single-port memory between the sequencer and counter-increment
// read-modify-write cycles, alternating grants when both are waiting.
module cycle_steal_arbiter
  import cycle_steal_arbiter_pkg::*;
#(
  parameter logic [11:0] CNT_BASE   = CNT_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [14:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic [14:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        cinc_valid,
  output logic        cinc_ready,
  input  logic [4:0]  cinc_idx,
  input  logic        cinc_dir,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [14:0] mem_wdata,
  input  logic [14:0] mem_rdata,
  output logic        ovf_pulse,
  output logic [4:0]  ovf_idx,
  output logic        busy
);

  arb_state_t state;
  logic       last_cinc;
  logic [4:0] ci_idx;
  logic       ci_dir;

  cinc_req_t  push_req;
  cinc_req_t  fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;

  assign push_req   = '{idx: cinc_idx, dir: cinc_dir};
  assign cinc_ready = !fifo_full;
  assign fifo_push  = cinc_valid && cinc_ready;
  assign fifo_pop   = (state == CI_RD);
  assign busy       = (state != IDLE) || !fifo_empty;

  inc_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_inc_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(push_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A request whose grant is still showing is already served; this stops a
  // held cpu_req from being granted twice right after a CPU write.
  logic cpu_pend;
  logic ci_pend;

  assign cpu_pend = cpu_req && !cpu_gnt;
  assign ci_pend  = !fifo_empty;

  // Ones-complement +/-1 with end-around carry and saturation-free overflow:
  // a wrapped result of the wrong sign is replaced by the matching zero.
  logic [WORD_W:0] oc_sum;
  word_t           oc_addend;
  word_t           oc_wrap;
  word_t           oc_result;
  logic            oc_pos_ovf;
  logic            oc_neg_ovf;

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    oc_addend  = ci_dir ? MINUS_ONE : PLUS_ONE;
    oc_sum     = {1'b0, mem_rdata} + {1'b0, oc_addend};
    oc_wrap    = oc_sum[WORD_W-1:0] + word_t'(oc_sum[WORD_W]);
    oc_pos_ovf = !mem_rdata[WORD_W-1] && !oc_addend[WORD_W-1] && oc_wrap[WORD_W-1];
    oc_neg_ovf = mem_rdata[WORD_W-1] && oc_addend[WORD_W-1] && !oc_wrap[WORD_W-1];
    oc_result  = oc_wrap;
    if (oc_pos_ovf)      oc_result = POS_ZERO;
    else if (oc_neg_ovf) oc_result = NEG_ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_cinc  <= 1'b1;
      ci_idx     <= '0;
      ci_dir     <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      ovf_pulse  <= 1'b0;
      ovf_idx    <= '0;
    end else begin
      mem_we     <= 1'b0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ovf_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_pend && (!ci_pend || last_cinc)) begin
            state     <= cpu_we ? CPU_WR : CPU_RD;
            last_cinc <= 1'b0;
          end else if (ci_pend) begin
            state     <= CI_RD;
            last_cinc <= 1'b1;
          end
        end
        CPU_RD: begin
          mem_addr <= cpu_addr;
          cpu_gnt  <= 1'b1;
          state    <= CPU_RDW;
        end
        CPU_RDW: begin
          cpu_rdata  <= mem_rdata;
          cpu_rvalid <= 1'b1;
          state      <= IDLE;
        end
        CPU_WR: begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          mem_we    <= 1'b1;
          cpu_gnt   <= 1'b1;
          state     <= IDLE;
        end
        CI_RD: begin
          ci_idx   <= fifo_head.idx;
          ci_dir   <= fifo_head.dir;
          mem_addr <= counter_addr(CNT_BASE, fifo_head.idx);
          state    <= CI_MOD;
        end
        CI_MOD: begin
          mem_we    <= 1'b1;
          mem_wdata <= oc_result;
          ovf_pulse <= oc_pos_ovf || oc_neg_ovf;
          ovf_idx   <= ci_idx;
          state     <= CI_WR;
        end
        CI_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_steal_arbiter.sv
// Scoreboard bench for cycle_steal_arbiter with a behavioural memory whose
// read data follows the registered address.
module tb_cycle_steal_arbiter;
  import cycle_steal_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [14:0] cpu_wdata;
  logic        cpu_gnt;
  logic [14:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cinc_valid;
  logic        cinc_ready;
  logic [4:0]  cinc_idx;
  logic        cinc_dir;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [14:0] mem_wdata;
  logic [14:0] mem_rdata;
  logic        ovf_pulse;
  logic [4:0]  ovf_idx;
  logic        busy;

  cycle_steal_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cinc_valid(cinc_valid),
    .cinc_ready(cinc_ready),
    .cinc_idx  (cinc_idx),
    .cinc_dir  (cinc_dir),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ovf_pulse (ovf_pulse),
    .ovf_idx   (ovf_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: reads follow the registered address, writes and preloads land on the edge.
  logic [14:0] mem       [0:4095];
  logic [14:0] model_mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [14:0] pre_data;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_wdata;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [14:0] data;
    logic        ovf;
    logic [4:0]  idx;
  } ci_exp_t;

  ci_exp_t     ci_q  [$];
  logic [14:0] rd_q  [$];
  bit          log_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          we_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ones-complement step computed on signed integers.
  task automatic oc_ref(input logic [14:0] w, input logic dir,
                        output logic [14:0] res, output logic ovf);
    int v;
    int r;
    v   = w[14] ? -int'((~w) & 15'h7FFF) : int'(w);
    r   = v + (dir ? -1 : 1);
    ovf = 1'b0;
    if (r > 16383) begin
      res = 15'h0000; ovf = 1'b1;
    end else if (r < -16383) begin
      res = 15'h7FFF; ovf = 1'b1;
    end else if (r == 0) begin
      res = 15'h7FFF;
    end else if (r > 0) begin
      res = 15'(r);
    end else begin
      res = ~15'(-r);
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      ci_exp_t e;
      if (cpu_rvalid) begin
        if (rd_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else                  check("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end
      if (cpu_gnt) log_q.push_back(1'b0);
      if (mem_we) we_cnt++;
      if (mem_we && !cpu_gnt) begin
        log_q.push_back(1'b1);
        if (ci_q.size() == 0) begin
          check("ci_write_unexpected", 1, 0);
        end else begin
          e = ci_q.pop_front();
          check("ci_addr", mem_addr, e.addr);
          check("ci_data", mem_wdata, e.data);
          check("ovf_pulse", ovf_pulse, e.ovf);
          if (e.ovf) check("ovf_idx", ovf_idx, e.idx);
        end
      end else if (ovf_pulse) begin
        check("ovf_stray", 1, 0);
      end
    end
  end

  task automatic preload(input logic [11:0] addr, input logic [14:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_en   = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic push_inc(input logic [4:0] idx, input logic dir, input bit applies);
    logic        r;
    int          waited;
    logic [11:0] a;
    logic [14:0] res;
    logic        ovf;
    cinc_valid = 1'b1;
    cinc_idx   = idx;
    cinc_dir   = dir;
    waited     = 0;
    do begin
      @(negedge clk) r = cinc_ready;
      @(posedge clk);
      waited++;
    end while (!r && waited < 100);
    if (!r) begin
      check("push_timeout", 0, 1);
    end else if (applies) begin
      a = 12'd20 + 12'(idx);
      oc_ref(model_mem[a], dir, res, ovf);
      model_mem[a] = res;
      ci_q.push_back('{addr: a, data: res, ovf: ovf, idx: idx});
    end
    #1 cinc_valid = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] addr,
                            input logic [14:0] wdata, output int lat);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (we) model_mem[addr] = wdata;
    else    rd_q.push_back(model_mem[addr]);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!cpu_gnt && lat < 100);
    if (!cpu_gnt) check("gnt_timeout", 0, 1);
    cpu_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (busy) check("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          bc;
    int          we0;
    int          drop_at;
    logic [5:0]  pat;
    logic [4:0]  burst_idx [5];
    logic        burst_dir [5];

    burst_idx = '{5'd8, 5'd8, 5'd9, 5'd8, 5'd10};
    burst_dir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cinc_valid = 1'b0;
    cinc_idx   = '0;
    cinc_dir   = 1'b0;
    pre_en     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;

    preload(12'h123, 15'h1555);
    preload(12'd23, 15'h3FFF);
    preload(12'd24, 15'h0000);
    preload(12'd25, 15'h7FFF);
    preload(12'd26, 15'h4000);
    preload(12'd27, 15'h0010);
    preload(12'd28, 15'h3FFE);
    preload(12'd29, 15'h0001);
    preload(12'd30, 15'h7FF0);
    for (int i = 31; i <= 33; i++) preload(12'(i), 15'h0100);
    preload(12'd34, 15'h0055);
    preload(12'd35, 15'h0066);

    // Reset state.
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ovf", {ovf_pulse, ovf_idx}, 0);
    check("rst_busy", busy, 0);
    check("rst_cinc_ready", cinc_ready, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle CPU read: grant two cycles after request, data one cycle later.
    cpu_access(1'b0, 12'h123, '0, lat);
    check("rd_gnt_latency", lat, 2);
    @(posedge clk);
    #1 check("rd_rvalid_next", cpu_rvalid, 1);
    wait_idle();

    // Positive overflow on idx 3; one arbitration cycle plus 3 owned cycles.
    we0 = we_cnt;
    push_inc(5'd3, 1'b0, 1'b1);
    bc = 0;
    repeat (10) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
    end
    check("inc_busy_cycles", bc, 4);
    check("inc_write_pulses", we_cnt - we0, 1);
    check("mem23_wrapped", mem[23], 15'h0000);

    // Signed-zero cases and negative overflow.
    push_inc(5'd4, 1'b1, 1'b1);
    push_inc(5'd5, 1'b0, 1'b1);
    push_inc(5'd6, 1'b1, 1'b1);
    wait_idle();
    check("mem24_minus_one", mem[24], 15'h7FFE);
    check("mem25_plus_one", mem[25], 15'h0001);

    // Burst of five behind a CPU write: FIFO fills after four.
    drop_at = 0;
    push_inc(5'd7, 1'b0, 1'b1);
    fork
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
          push_inc(burst_idx[i], burst_dir[i], 1'b1);
          if (!cinc_ready && drop_at == 0) drop_at = i + 1;
        end
      end
      begin
        int l;
        repeat (2) @(posedge clk);
        #1 cpu_access(1'b1, 12'h200, 15'h0ABC, l);
      end
    join
    check("ready_drop_after", drop_at, 4);
    wait_idle();
    cpu_access(1'b0, 12'h200, '0, lat);
    wait_idle();

    // Fresh reset, then contention: CPU first, then strict alternation.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
    push_inc(5'd11, 1'b0, 1'b1);
    fork
      begin
        int l;
        for (int i = 0; i < 3; i++) cpu_access(1'b1, 12'h300 + 12'(i), 15'h0100 + 15'(i), l);
      end
      begin
        push_inc(5'd12, 1'b0, 1'b1);
        push_inc(5'd13, 1'b1, 1'b1);
      end
    join
    wait_idle();
    check("grant_count", log_q.size(), 6);
    pat = '0;
    for (int i = 0; i < 6 && i < log_q.size(); i++) pat[5-i] = log_q[i];
    check("grant_order", pat, 6'b010101);

    // Reset while an RMW sits in CI_MOD with one more entry queued.
    we0 = we_cnt;
    push_inc(5'd14, 1'b0, 1'b0);
    push_inc(5'd15, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rmw_abort_ready", cinc_ready, 1);
    check("rmw_abort_busy", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    check("rmw_abort_no_write", we_cnt - we0, 0);
    check("rmw_abort_still_idle", busy, 0);
    check("mem34_untouched", mem[34], 15'h0055);

    check("ci_queue_drained", ci_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
